// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle between the control unit and the multi-cycle ALU.
interface alu_seq_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic [2:0]       ALUControl;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ALUResult;
  logic [3:0]       ALUFlags;

  modport master (
    output in_valid, SrcA, SrcB, ALUControl, out_ready,
    input  in_ready, out_valid, ALUResult, ALUFlags
  );

  modport slave (
    input  in_valid, SrcA, SrcB, ALUControl, out_ready,
    output in_ready, out_valid, ALUResult, ALUFlags
  );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle integer ALU: single-cycle add/sub/logic, WIDTH-step shift-add multiply
// and restoring unsigned divide, with valid/ready handshakes on both sides.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     reset,
  alu_seq_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ITER = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_MUL  = 3'b100;
  localparam logic [2:0] OP_UDIV = 3'b101;
  localparam logic [2:0] OP_UREM = 3'b110;
  localparam logic [2:0] OP_EOR  = 3'b111;

  function automatic logic [1:0] nz_flags(input logic [WIDTH-1:0] r);
    nz_flags = {r[WIDTH-1], (r == {WIDTH{1'b0}})};
  endfunction

  function automatic logic is_iter_op(input logic [2:0] op);
    is_iter_op = (op == OP_MUL) || (op == OP_UDIV) || (op == OP_UREM);
  endfunction

  state_t           state_r, state_s;
  logic [2:0]       op_r, op_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic [WIDTH-1:0] acc_r, acc_s;
  logic [WIDTH-1:0] x_r, x_s;
  logic [WIDTH-1:0] y_r, y_s;
  logic             dz_r, dz_s;
  logic [WIDTH-1:0] result_r, result_s;
  logic [3:0]       flags_r, flags_s;
  logic             in_ready_r, in_ready_s;
  logic             out_valid_r, out_valid_s;

  logic [WIDTH-1:0] b_mux_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] alu_res_s;
  logic             alu_c_s;
  logic             alu_v_s;

  logic [WIDTH-1:0] mul_acc_s;
  logic [WIDTH:0]   rem_sh_s;
  logic             ge_s;
  logic [WIDTH-1:0] diff_s;
  logic [WIDTH-1:0] div_rem_s;
  logic [WIDTH-1:0] div_q_s;
  logic [WIDTH-1:0] iter_res_s;

  // Single-cycle datapath, evaluated on the live operands at accept time.
  always_comb begin
    b_mux_s   = bus.ALUControl[0] ? ~bus.SrcB : bus.SrcB;
    sum_s     = {1'b0, bus.SrcA} + {1'b0, b_mux_s} + {{WIDTH{1'b0}}, bus.ALUControl[0]};
    alu_res_s = sum_s[WIDTH-1:0];
    alu_c_s   = 1'b0;
    alu_v_s   = 1'b0;
    case (bus.ALUControl)
      OP_ADD, OP_SUB: begin
        alu_res_s = sum_s[WIDTH-1:0];
        alu_c_s   = sum_s[WIDTH];
        alu_v_s   = ~(bus.SrcA[WIDTH-1] ^ bus.SrcB[WIDTH-1] ^ bus.ALUControl[0]) &
                    (bus.SrcA[WIDTH-1] ^ sum_s[WIDTH-1]);
      end
      OP_AND:  alu_res_s = bus.SrcA & bus.SrcB;
      OP_OR:   alu_res_s = bus.SrcA | bus.SrcB;
      OP_EOR:  alu_res_s = bus.SrcA ^ bus.SrcB;
      default: alu_res_s = sum_s[WIDTH-1:0];
    endcase
  end

  // One iteration step: x shifts left (multiplicand / dividend-then-quotient), y is multiplier or divisor.
  always_comb begin
    mul_acc_s = y_r[0] ? (acc_r + x_r) : acc_r;
    rem_sh_s  = {acc_r, x_r[WIDTH-1]};
    ge_s      = (rem_sh_s >= {1'b0, y_r});
    diff_s    = rem_sh_s[WIDTH-1:0] - y_r;
    div_rem_s = ge_s ? diff_s : rem_sh_s[WIDTH-1:0];
    div_q_s   = {x_r[WIDTH-2:0], ge_s};
    case (op_r)
      OP_MUL:  iter_res_s = mul_acc_s;
      OP_UDIV: iter_res_s = div_q_s;
      default: iter_res_s = div_rem_s;
    endcase
  end

  // Next-state and next-output logic; outputs are registered from these values.
  always_comb begin
    state_s     = state_r;
    op_s        = op_r;
    cnt_s       = cnt_r;
    acc_s       = acc_r;
    x_s         = x_r;
    y_s         = y_r;
    dz_s        = dz_r;
    result_s    = result_r;
    flags_s     = flags_r;
    out_valid_s = out_valid_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.in_valid && in_ready_r) begin
          op_s  = bus.ALUControl;
          cnt_s = CNT_ZERO;
          dz_s  = (bus.SrcB == {WIDTH{1'b0}});
          if (is_iter_op(bus.ALUControl)) begin
            state_s = ST_ITER;
            acc_s   = {WIDTH{1'b0}};
            x_s     = bus.SrcA;
            y_s     = bus.SrcB;
          end else begin
            state_s     = ST_DONE;
            result_s    = alu_res_s;
            flags_s     = {nz_flags(alu_res_s), alu_c_s, alu_v_s};
            out_valid_s = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ITER: begin
        cnt_s = cnt_r + CNT_ONE;
        if (op_r == OP_MUL) begin
          acc_s = mul_acc_s;
          x_s   = {x_r[WIDTH-2:0], 1'b0};
          y_s   = {1'b0, y_r[WIDTH-1:1]};
        end else begin
          acc_s = div_rem_s;
          x_s   = div_q_s;
        end
        if (cnt_r == CNT_LAST) begin
          state_s     = ST_DONE;
          result_s    = iter_res_s;
          flags_s     = {nz_flags(iter_res_s), 1'b0, (op_r != OP_MUL) & dz_r};
          out_valid_s = 1'b1;
        end else begin
          state_s = ST_ITER;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_s     = ST_IDLE;
          out_valid_s = 1'b0;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s     = ST_IDLE;
        out_valid_s = 1'b0;
      end
    endcase
    in_ready_s = (state_s == ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      op_r        <= 3'b000;
      cnt_r       <= CNT_ZERO;
      acc_r       <= {WIDTH{1'b0}};
      x_r         <= {WIDTH{1'b0}};
      y_r         <= {WIDTH{1'b0}};
      dz_r        <= 1'b0;
      result_r    <= {WIDTH{1'b0}};
      flags_r     <= 4'b0000;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      op_r        <= op_s;
      cnt_r       <= cnt_s;
      acc_r       <= acc_s;
      x_r         <= x_s;
      y_r         <= y_s;
      dz_r        <= dz_s;
      result_r    <= result_s;
      flags_r     <= flags_s;
      in_ready_r  <= in_ready_s;
      out_valid_r <= out_valid_s;
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.ALUResult = result_r;
  assign bus.ALUFlags  = flags_r;

endmodule
